// File: rtl/display_button_scanner.sv
// display_button_scanner: loads, shifts out and debounces the button shift
// register, with Avalon-MM status registers. Optional irq: `define BUTTON_IRQ_EN.
module display_button_scanner #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SHIFT_HZ       = 1_000_000,
  parameter int SCAN_HZ        = 1_000,
  parameter int NUM_BITS       = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        shift_clk,
  output logic        shift_load,
  input  logic        shift_out,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata
`ifdef BUTTON_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int DIV      = CLK_HZ / (2 * SHIFT_HZ);
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int CW = $clog2(2 * DIV + 1);
  localparam int TW = $clog2(SCAN_DIV + 1);
  localparam int IW = $clog2(NUM_BITS + 1);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [CW-1:0] LOAD_LAST = CW'(2 * DIV - 1);
  localparam logic [CW-1:0] PH_LAST   = CW'(DIV - 1);
  localparam logic [TW-1:0] TMR_LAST  = TW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(NUM_BITS - 1);
  localparam logic [SW-1:0] STB_MAX   = SW'(DEBOUNCE_SCANS);
  localparam logic [SW-1:0] STB_ONE   = SW'(1);
  localparam logic [31:0]   VMASK     = (NUM_BITS >= 32) ? 32'hFFFF_FFFF
                                        : 32'((64'd1 << NUM_BITS) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_UPDATE
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       bit_idx;
  logic [IW-1:0]       ridx;
  logic [NUM_BITS-1:0] raw_q;
  logic [TW-1:0]       tmr;
  logic                scan_req;
  logic                start;

  logic [SW-1:0]       stable;
  logic [SW-1:0]       stable_nxt;
  logic [NUM_BITS-1:0] last_raw;
  logic [NUM_BITS-1:0] buttons;
  logic [NUM_BITS-1:0] changed;
  logic [NUM_BITS-1:0] set_bits;
  logic [NUM_BITS-1:0] wr_clr;
  logic                upd_en;
  logic [31:0]         scan_count;
  logic [31:0]         rd_val;
  logic                unused_wdata;

  assign start        = (state == S_IDLE) && scan_req;
  assign ridx         = BIT_LAST - bit_idx;
  assign unused_wdata = ^(avs_writedata & ~VMASK);

  // free-running scan timer; a wrap queues one scan request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr      <= '0;
      scan_req <= 1'b0;
    end else begin
      if (tmr == TMR_LAST) begin
        tmr      <= '0;
        scan_req <= 1'b1;
      end else begin
        tmr <= tmr + TW'(1);
        if (start) scan_req <= 1'b0;
      end
    end
  end

  // scan sequencer: load, then MSB-first shift with registered pin outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      raw_q      <= '0;
      shift_clk  <= 1'b0;
      shift_load <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (scan_req) begin
            shift_load <= 1'b0;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (cnt == LOAD_LAST) begin
            cnt        <= '0;
            bit_idx    <= '0;
            shift_load <= 1'b1;
            state      <= S_SHIFT_LO;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_SHIFT_LO: begin
          if (cnt == PH_LAST) begin
            cnt         <= '0;
            raw_q[ridx] <= ~shift_out;
            if (bit_idx == BIT_LAST) begin
              state <= S_UPDATE;
            end else begin
              shift_clk <= 1'b1;
              state     <= S_SHIFT_HI;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_SHIFT_HI: begin
          if (cnt == PH_LAST) begin
            cnt       <= '0;
            shift_clk <= 1'b0;
            bit_idx   <= bit_idx + IW'(1);
            state     <= S_SHIFT_LO;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_UPDATE: begin
          state <= S_IDLE;
        end
        default: begin
          state      <= S_IDLE;
          shift_clk  <= 1'b0;
          shift_load <= 1'b1;
        end
      endcase
    end
  end

  // whole-vector stability count and the resulting change set
  always_comb begin
    stable_nxt = STB_ONE;
    if (raw_q == last_raw) begin
      stable_nxt = (stable == STB_MAX) ? STB_MAX : stable + SW'(1);
    end
    upd_en   = (state == S_UPDATE) && (stable_nxt == STB_MAX)
               && (raw_q != buttons);
    set_bits = upd_en ? (raw_q ^ buttons) : '0;
  end

  // debounce state, debounced vector and scan counter, once per scan
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable     <= '0;
      last_raw   <= '0;
      buttons    <= '0;
      scan_count <= '0;
    end else if (state == S_UPDATE) begin
      stable     <= stable_nxt;
      last_raw   <= raw_q;
      scan_count <= scan_count + 32'd1;
      if (upd_en) buttons <= raw_q;
    end
  end

  assign wr_clr = (avs_write && (avs_address == 2'd1))
                  ? avs_writedata[NUM_BITS-1:0] : '0;

  // sticky change flags; a new set beats a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      changed <= '0;
    end else begin
      changed <= (changed & ~wr_clr) | set_bits;
    end
  end

`ifdef BUTTON_IRQ_EN
  logic [NUM_BITS-1:0] irq_mask;

  // interrupt mask register and registered interrupt level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (avs_write && (avs_address == 2'd3)) begin
        irq_mask <= avs_writedata[NUM_BITS-1:0];
      end
      irq <= |(changed & irq_mask);
    end
  end
`endif

  // read mux over current (pre-write) register values
  always_comb begin
    rd_val = '0;
    unique case (avs_address)
      2'd0: rd_val = 32'(buttons);
      2'd1: rd_val = 32'(changed);
      2'd2: rd_val = scan_count;
      2'd3: begin
`ifdef BUTTON_IRQ_EN
        rd_val = 32'(irq_mask);
`else
        rd_val = '0;
`endif
      end
      default: rd_val = '0;
    endcase
  end

  // read data register, readLatency 1, holds between reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rd_val;
    end
  end

endmodule
